ctrl_decode_stage: RTL and testbench

Registered, parametrised successor to the combinational control unit. It decodes mode/op_code/S into execute command and control enables, gates them with ARM condition-code evaluation, and holds the result in the ID/EX pipeline register. The register supports stall and flush. A new multi-cycle MUL mode holds the stage busy for a configurable number of cycles. The block sits between the instruction decode and execute stages and feeds the EX-stage ALU, memory and write-back controls directly.

---
 rtl/ctrl_pkg.sv | 88 ++++++++
 rtl/ctrl_decode_stage_cond_check.sv | 33 +++
 rtl/ctrl_decode_stage.sv | 96 +++++++++
 tb/tb_ctrl_decode_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings and the decode table for the ID/EX control stage.
package ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_ALU = 2'b00,
        MODE_MEM = 2'b01,
        MODE_BR  = 2'b10,
        MODE_MUL = 2'b11
    } mode_e;

    localparam logic [3:0] OP_AND = 4'b0000, OP_EOR = 4'b0001, OP_SUB = 4'b0010,
                           OP_ADD = 4'b0100, OP_ADC = 4'b0101, OP_SBC = 4'b0110,
                           OP_TST = 4'b1000, OP_CMP = 4'b1010, OP_ORR = 4'b1100,
                           OP_MOV = 4'b1101, OP_MVN = 4'b1111;

    localparam logic [3:0] CMD_NOP = 4'b0000, CMD_MOV = 4'b0001, CMD_ADD = 4'b0010,
                           CMD_ADC = 4'b0011, CMD_SUB = 4'b0100, CMD_SBC = 4'b0101,
                           CMD_AND = 4'b0110, CMD_ORR = 4'b0111, CMD_EOR = 4'b1000,
                           CMD_MVN = 4'b1001, CMD_MUL = 4'b1010;

    localparam logic [3:0] COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
                           COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
                           COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
                           COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF;

    typedef struct packed {
        logic       valid;
        logic [3:0] cmd;
        logic       mem_read;
        logic       mem_write;
        logic       wb_en;
        logic       b;
        logic       update_sr;
    } ctrl_t;

    typedef struct packed {
        ctrl_t ctrl;
        logic  illegal;
        logic  is_mul;
    } dec_t;

    // MUL leaves wb_en clear; the stage raises it in the final MUL cycle.
    function automatic dec_t decode(input mode_e mode, input logic [3:0] op, input logic s);
        dec_t d;
        d = '0;
        d.ctrl.valid = 1'b1;
        case (mode)
            MODE_ALU: begin
                d.ctrl.update_sr = s;
                d.ctrl.wb_en     = 1'b1;
                case (op)
                    OP_MOV: d.ctrl.cmd = CMD_MOV;
                    OP_MVN: d.ctrl.cmd = CMD_MVN;
                    OP_ADD: d.ctrl.cmd = CMD_ADD;
                    OP_ADC: d.ctrl.cmd = CMD_ADC;
                    OP_SUB: d.ctrl.cmd = CMD_SUB;
                    OP_SBC: d.ctrl.cmd = CMD_SBC;
                    OP_AND: d.ctrl.cmd = CMD_AND;
                    OP_ORR: d.ctrl.cmd = CMD_ORR;
                    OP_EOR: d.ctrl.cmd = CMD_EOR;
                    OP_CMP, OP_TST: begin
                        d.ctrl.cmd       = (op == OP_CMP) ? CMD_SUB : CMD_AND;
                        d.ctrl.wb_en     = 1'b0;
                        d.ctrl.update_sr = 1'b1;
                    end
                    default: begin
                        d.ctrl    = '0;
                        d.illegal = 1'b1;
                    end
                endcase
            end
            MODE_MEM: begin
                d.ctrl.cmd       = CMD_ADD;
                d.ctrl.mem_read  = s;
                d.ctrl.mem_write = !s;
                d.ctrl.wb_en     = s;
            end
            MODE_BR: d.ctrl.b = 1'b1;
            MODE_MUL: begin
                d.ctrl.cmd       = CMD_MUL;
                d.ctrl.update_sr = s;
                d.is_mul         = 1'b1;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/ctrl_decode_stage_cond_check.sv
// ARM condition-code evaluation against the sampled NZCV flags.
module cond_check
    import ctrl_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] nzcv_i,
    output logic       pass_o
);
    logic n, z, c, v;
    assign {n, z, c, v} = nzcv_i;

    always_comb begin
        pass_o = 1'b0;
        case (cond_i)
            COND_EQ: pass_o = z;
            COND_NE: pass_o = !z;
            COND_CS: pass_o = c;
            COND_CC: pass_o = !c;
            COND_MI: pass_o = n;
            COND_PL: pass_o = !n;
            COND_VS: pass_o = v;
            COND_VC: pass_o = !v;
            COND_HI: pass_o = c && !z;
            COND_LS: pass_o = !c || z;
            COND_GE: pass_o = (n == v);
            COND_LT: pass_o = (n != v);
            COND_GT: pass_o = !z && (n == v);
            COND_LE: pass_o = z || (n != v);
            COND_AL: pass_o = 1'b1;
            default: pass_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/ctrl_decode_stage.sv
// ID/EX control register: decode, condition gating, stall/flush and MUL occupancy.
module ctrl_decode_stage
    import ctrl_pkg::*;
#(
    parameter int CMD_W      = 4,
    parameter int MUL_CYCLES = 3,
    parameter int COND_EN    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [1:0]       mode_i,
    input  logic [3:0]       op_code_i,
    input  logic             s_i,
    input  logic [3:0]       cond_i,
    input  logic [3:0]       nzcv_i,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic             valid_o,
    output logic [CMD_W-1:0] exe_cmd_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             wb_en_o,
    output logic             b_o,
    output logic             update_sr_o,
    output logic             busy_o,
    output logic             illegal_o
);
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    ctrl_t            ctrl_q, ctrl_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             cond_pass, pass;
    dec_t             dec;

    cond_check u_cond (
        .cond_i (cond_i),
        .nzcv_i (nzcv_i),
        .pass_o (cond_pass)
    );

    assign pass = (COND_EN == 0) ? 1'b1 : cond_pass;
    assign dec  = decode(mode_e'(mode_i), op_code_i, s_i);

    always_comb begin
        ctrl_d    = ctrl_q;
        cnt_d     = cnt_q;
        illegal_d = 1'b0;
        if (flush_i) begin
            ctrl_d = '0;
            cnt_d  = '0;
        end else if (stall_i) begin
            ctrl_d = ctrl_q;
        end else if (cnt_q != '0) begin
            // Write-back fires only in the cycle the count lands on zero.
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) ctrl_d.wb_en = 1'b1;
        end else begin
            ctrl_d = '0;
            cnt_d  = '0;
            if (valid_i) begin
                illegal_d = dec.illegal;
                if (pass && !dec.illegal) begin
                    ctrl_d = dec.ctrl;
                    if (dec.is_mul) begin
                        cnt_d        = CNT_W'(MUL_CYCLES - 1);
                        ctrl_d.wb_en = (MUL_CYCLES == 1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q    <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    assign valid_o     = ctrl_q.valid;
    assign exe_cmd_o   = CMD_W'(ctrl_q.cmd);
    assign mem_read_o  = ctrl_q.mem_read;
    assign mem_write_o = ctrl_q.mem_write;
    assign wb_en_o     = ctrl_q.wb_en;
    assign b_o         = ctrl_q.b;
    assign update_sr_o = ctrl_q.update_sr;
    assign busy_o      = (cnt_q != '0);
    assign illegal_o   = illegal_q;
endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Directed plus random checks of ctrl_decode_stage against a table-driven model.
module tb_ctrl_decode_stage;
    localparam int MULC = 3;

    logic       clk = 1'b0;
    logic       rst, valid_i, s_i, stall_i, flush_i;
    logic [1:0] mode_i;
    logic [3:0] op_code_i, cond_i, nzcv_i;
    logic       valid_o, mem_read_o, mem_write_o, wb_en_o, b_o, update_sr_o, busy_o, illegal_o;
    logic [3:0] exe_cmd_o;

    int checks = 0;
    int errors = 0;

    // model state
    bit       m_valid, m_mr, m_mw, m_wb, m_b, m_usr, m_ill;
    int       m_cmd, m_rem;
    int       alu_cmd [16];
    bit       alu_ok  [16];
    bit       alu_wb  [16];
    bit       alu_fsr [16];

    ctrl_decode_stage #(.CMD_W(4), .MUL_CYCLES(MULC), .COND_EN(1)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .mode_i(mode_i), .op_code_i(op_code_i),
        .s_i(s_i), .cond_i(cond_i), .nzcv_i(nzcv_i), .stall_i(stall_i), .flush_i(flush_i),
        .valid_o(valid_o), .exe_cmd_o(exe_cmd_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .wb_en_o(wb_en_o), .b_o(b_o), .update_sr_o(update_sr_o),
        .busy_o(busy_o), .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int op, input int cmd, input bit wb, input bit fsr);
        alu_ok[op]  = 1'b1;
        alu_cmd[op] = cmd;
        alu_wb[op]  = wb;
        alu_fsr[op] = fsr;
    endtask

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (int'(c))
            0: return z;          1: return !z;
            2: return cy;         3: return !cy;
            4: return n;          5: return !n;
            6: return v;          7: return !v;
            8: return cy && !z;   9: return !cy || z;
            10: return n == v;    11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_clear();
        m_valid = 0; m_mr = 0; m_mw = 0; m_wb = 0; m_b = 0; m_usr = 0; m_ill = 0;
        m_cmd = 0; m_rem = 0;
    endtask

    task automatic model_edge();
        if (rst || flush_i) begin
            model_clear();
        end else if (stall_i) begin
            m_ill = 0;
        end else if (m_rem > 0) begin
            m_ill = 0;
            m_rem = m_rem - 1;
            if (m_rem == 0) m_wb = 1;
        end else begin
            model_clear();
            if (valid_i) begin
                m_ill = (mode_i == 2'd0) && !alu_ok[op_code_i];
                if (!m_ill && cond_ok(cond_i, nzcv_i)) begin
                    m_valid = 1;
                    case (mode_i)
                        2'd0: begin
                            m_cmd = alu_cmd[op_code_i];
                            m_wb  = alu_wb[op_code_i];
                            m_usr = alu_fsr[op_code_i] ? 1'b1 : s_i;
                        end
                        2'd1: begin
                            m_cmd = 2; m_mr = s_i; m_mw = !s_i; m_wb = s_i;
                        end
                        2'd2: m_b = 1;
                        default: begin
                            m_cmd = 10; m_usr = s_i;
                            m_rem = MULC - 1;
                            m_wb  = (m_rem == 0);
                        end
                    endcase
                end
            end
        end
    endtask

    task automatic check_all();
        chk("valid",     32'(valid_o),     32'(m_valid));
        chk("cmd",       32'(exe_cmd_o),   32'(m_cmd));
        chk("mem_read",  32'(mem_read_o),  32'(m_mr));
        chk("mem_write", 32'(mem_write_o), 32'(m_mw));
        chk("wb_en",     32'(wb_en_o),     32'(m_wb));
        chk("b",         32'(b_o),         32'(m_b));
        chk("update_sr", 32'(update_sr_o), 32'(m_usr));
        chk("busy",      32'(busy_o),      32'(m_rem != 0));
        chk("illegal",   32'(illegal_o),   32'(m_ill));
    endtask

    // drive one cycle, advance the model at the edge, check just after it
    task automatic cyc(input logic v, input logic [1:0] m, input logic [3:0] op, input logic s,
                       input logic [3:0] c, input logic [3:0] f,
                       input logic st, input logic fl, input logic r);
        valid_i = v; mode_i = m; op_code_i = op; s_i = s; cond_i = c; nzcv_i = f;
        stall_i = st; flush_i = fl; rst = r;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        cyc(0, 2'd0, 4'd0, 0, 4'hE, 4'd0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            alu_ok[i] = 0; alu_cmd[i] = 0; alu_wb[i] = 0; alu_fsr[i] = 0;
        end
        set_op(13, 1, 1, 0); set_op(15, 9, 1, 0); set_op(4, 2, 1, 0);
        set_op(5, 3, 1, 0);  set_op(2, 4, 1, 0);  set_op(6, 5, 1, 0);
        set_op(0, 6, 1, 0);  set_op(12, 7, 1, 0); set_op(1, 8, 1, 0);
        set_op(10, 4, 0, 1); set_op(8, 6, 0, 1);
        model_clear();

        // reset
        cyc(0, 2'd0, 4'd0, 0, 4'hE, 4'd0, 0, 0, 1);
        cyc(0, 2'd0, 4'd0, 0, 4'hE, 4'd0, 0, 0, 1);
        chk("rst_valid", 32'(valid_o), 32'h0);

        // ADD S=1 AL
        cyc(1, 2'd0, 4'b0100, 1, 4'hE, 4'd0, 0, 0, 0);
        chk("add_cmd", 32'(exe_cmd_o), 32'h2);
        chk("add_wb", 32'(wb_en_o), 32'h1);
        chk("add_sr", 32'(update_sr_o), 32'h1);

        // CMP EQ pass / fail
        cyc(1, 2'd0, 4'b1010, 0, 4'h0, 4'b0100, 0, 0, 0);
        chk("cmp_cmd", 32'(exe_cmd_o), 32'h4);
        chk("cmp_wb", 32'(wb_en_o), 32'h0);
        chk("cmp_sr", 32'(update_sr_o), 32'h1);
        cyc(1, 2'd0, 4'b1010, 0, 4'h0, 4'b0000, 0, 0, 0);
        chk("cmp_fail_valid", 32'(valid_o), 32'h0);

        // LDR then STR
        cyc(1, 2'd1, 4'd0, 1, 4'hE, 4'd0, 0, 0, 0);
        chk("ldr_rd", 32'(mem_read_o), 32'h1);
        chk("ldr_wb", 32'(wb_en_o), 32'h1);
        cyc(1, 2'd1, 4'd0, 0, 4'hE, 4'd0, 0, 0, 0);
        chk("str_wr", 32'(mem_write_o), 32'h1);
        chk("str_wb", 32'(wb_en_o), 32'h0);

        // MUL, 3 cycles
        cyc(1, 2'd3, 4'd0, 1, 4'hE, 4'd0, 0, 0, 0);
        chk("mul_busy1", 32'(busy_o), 32'h1);
        chk("mul_wb1", 32'(wb_en_o), 32'h0);
        idle();
        chk("mul_busy2", 32'(busy_o), 32'h1);
        idle();
        chk("mul_busy3", 32'(busy_o), 32'h0);
        chk("mul_wb3", 32'(wb_en_o), 32'h1);
        idle();

        // MUL with a stall in the middle
        cyc(1, 2'd3, 4'd0, 0, 4'hE, 4'd0, 0, 0, 0);
        idle();
        cyc(0, 2'd0, 4'd0, 0, 4'hE, 4'd0, 1, 0, 0);
        chk("mul_stall_busy", 32'(busy_o), 32'h1);
        idle();
        chk("mul_stall_wb", 32'(wb_en_o), 32'h1);
        idle();

        // MUL aborted by flush
        cyc(1, 2'd3, 4'd0, 0, 4'hE, 4'd0, 0, 0, 0);
        cyc(0, 2'd0, 4'd0, 0, 4'hE, 4'd0, 0, 1, 0);
        chk("flush_busy", 32'(busy_o), 32'h0);
        chk("flush_valid", 32'(valid_o), 32'h0);
        idle();
        chk("flush_nowb", 32'(wb_en_o), 32'h0);

        // illegal opcode, then stall keeps it from re-pulsing
        cyc(1, 2'd0, 4'b0011, 0, 4'hE, 4'd0, 0, 0, 0);
        chk("ill_pulse", 32'(illegal_o), 32'h1);
        chk("ill_valid", 32'(valid_o), 32'h0);
        cyc(1, 2'd0, 4'b0011, 0, 4'hE, 4'd0, 1, 0, 0);
        chk("ill_stall", 32'(illegal_o), 32'h0);

        // stall + flush together, and flush with a valid instruction
        cyc(1, 2'd0, 4'b1101, 0, 4'hE, 4'd0, 0, 0, 0);
        cyc(1, 2'd0, 4'b1101, 0, 4'hE, 4'd0, 1, 1, 0);
        chk("stflush_valid", 32'(valid_o), 32'h0);
        cyc(1, 2'd2, 4'd0, 0, 4'hE, 4'd0, 0, 1, 0);
        chk("flush_drop", 32'(b_o), 32'h0);

        // reset mid-MUL
        cyc(1, 2'd3, 4'd0, 0, 4'hE, 4'd0, 0, 0, 0);
        cyc(0, 2'd0, 4'd0, 0, 4'hE, 4'd0, 0, 0, 1);
        chk("rst_mul_busy", 32'(busy_o), 32'h0);
        idle();

        // random traffic
        for (int k = 0; k < 600; k++) begin
            logic [3:0] rc;
            rc = ($urandom_range(0, 1) == 1) ? 4'hE : 4'($urandom());
            cyc(1'($urandom()), 2'($urandom()), 4'($urandom()), 1'($urandom()), rc,
                4'($urandom()), ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 49) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
